// File: rtl/dev_uart_tx_pkg.sv
// Shared register offsets, STATUS bit positions and state encodings for dev_uart_tx.
// The S_PAR state only exists when UART_PARITY_EN is defined.
package dev_uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_PARITY    = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam int RESET_DIV = 868;

  typedef enum logic [1:0] {B_IDLE, B_RESP, B_WAIT} bus_state_t;

`ifdef UART_PARITY_EN
  localparam logic PARITY_BUILT_IN = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} ser_state_t;
`else
  localparam logic PARITY_BUILT_IN = 1'b0;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;
`endif

endpackage

// File: rtl/uart_tx_serializer.sv
// Frame serializer: pops bytes from the FIFO head and shifts them out 8N1 (8E1 with UART_PARITY_EN).
// The divisor is latched per frame, so divisor writes only affect the next frame.
module uart_tx_serializer
  import dev_uart_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] div,
  input  logic        head_valid,
  input  logic [7:0]  head_data,
  output logic        pop,
  output logic        busy,
  output logic        tx
);

  ser_state_t  state, state_next;
  logic [15:0] div_q;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        bit_end;
  logic        load;

  assign bit_end = (cnt == 16'd0);
  assign pop     = load;
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    tx         = 1'b1;
    case (state)
      S_IDLE: begin
        if (head_valid) begin
          load       = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        tx = shreg[bit_idx];
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
          state_next = S_PAR;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: begin
        tx = ^shreg;
        if (bit_end) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit so queued bytes go out without an idle gap.
        if (bit_end) begin
          if (head_valid) begin
            load       = 1'b1;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      div_q   <= 16'd1;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      state <= state_next;
      if (load) begin
        shreg   <= head_data;
        div_q   <= div;
        cnt     <= div - 16'd1;
        bit_idx <= 3'd0;
      end else if (state != S_IDLE) begin
        if (bit_end) begin
          cnt <= div_q - 16'd1;
          if (state == S_DATA) bit_idx <= bit_idx + 3'd1;
        end else begin
          cnt <= cnt - 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/dev_uart_tx.sv
// Memory-mapped UART transmitter on the M_DEVICE port: bus FSM, TX FIFO and registers.
// Define UART_PARITY_EN to add an even-parity bit to every frame.
module dev_uart_tx
  import dev_uart_tx_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = RESET_DIV
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dev_strobe_i,
  input  logic [XLEN-1:0]   dev_addr_i,
  input  logic              dev_rw_i,
  input  logic [XLEN/8-1:0] dev_byte_en_i,
  input  logic [XLEN-1:0]   dev_data_i,
  output logic              dev_ready_o,
  output logic [XLEN-1:0]   dev_data_o,
  output logic              tx_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  bus_state_t      bus_state, bus_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW:0]     wptr, rptr, count;
  logic            full, empty, push, pop, busy, div_we;
  logic [7:0]      push_data, req_byte;
  logic [15:0]     div_reg, div_eff;
  logic [1:0]      cur_reg;
  logic            is_push_req;
  logic [XLEN-1:0] status_word, read_value, rdata;
  logic            unused_bits;

  assign unused_bits = ^{dev_addr_i[XLEN-1:4], dev_addr_i[1:0],
                         dev_data_i[XLEN-1:16], dev_byte_en_i[XLEN/8-1:2]};

  assign cur_reg     = dev_addr_i[3:2];
  assign is_push_req = dev_rw_i && (cur_reg == REG_TXDATA) && dev_byte_en_i[0];
  assign count       = wptr - rptr;
  assign full        = (count == (PW+1)'(FIFO_DEPTH));
  assign empty       = (wptr == rptr);
  assign div_eff     = (div_reg == 16'd0) ? 16'd1 : div_reg;
  assign dev_ready_o = (bus_state == B_RESP);
  assign dev_data_o  = dev_ready_o ? rdata : '0;

  always_comb begin
    status_word                            = '0;
    status_word[STAT_FULL]                 = full;
    status_word[STAT_EMPTY]                = empty;
    status_word[STAT_BUSY]                 = busy;
    status_word[STAT_PARITY]               = PARITY_BUILT_IN;
    status_word[STAT_COUNT_LSB +: PW+1]    = count;
  end

  always_comb begin
    read_value = '0;
    case (cur_reg)
      REG_STATUS:  read_value = status_word;
      REG_DIVISOR: read_value[15:0] = div_reg;
      default:     read_value = '0;
    endcase
  end

  // A push that finds the FIFO full parks in B_WAIT and is acked only once it lands.
  always_comb begin
    bus_next  = bus_state;
    push      = 1'b0;
    push_data = dev_data_i[7:0];
    div_we    = 1'b0;
    case (bus_state)
      B_IDLE: begin
        if (dev_strobe_i) begin
          if (is_push_req && full) begin
            bus_next = B_WAIT;
          end else begin
            bus_next = B_RESP;
            push     = is_push_req;
            div_we   = dev_rw_i && (cur_reg == REG_DIVISOR);
          end
        end
      end
      B_RESP: bus_next = B_IDLE;
      B_WAIT: begin
        push_data = req_byte;
        if (!full) begin
          push     = 1'b1;
          bus_next = B_RESP;
        end
      end
      default: bus_next = B_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus_state <= B_IDLE;
      wptr      <= '0;
      rptr      <= '0;
      div_reg   <= 16'(DEFAULT_DIV);
      rdata     <= '0;
      req_byte  <= 8'd0;
    end else begin
      bus_state <= bus_next;
      if (bus_state == B_IDLE && dev_strobe_i) begin
        req_byte <= dev_data_i[7:0];
        rdata    <= dev_rw_i ? '0 : read_value;
      end
      if (push) wptr <= wptr + (PW+1)'(1);
      if (pop)  rptr <= rptr + (PW+1)'(1);
      if (div_we) begin
        if (dev_byte_en_i[0]) div_reg[7:0]  <= dev_data_i[7:0];
        if (dev_byte_en_i[1]) div_reg[15:8] <= dev_data_i[15:8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[PW-1:0]] <= push_data;
  end

  uart_tx_serializer u_serializer (
    .clk        (clk_i),
    .rst        (rst_i),
    .div        (div_eff),
    .head_valid (!empty),
    .head_data  (mem[rptr[PW-1:0]]),
    .pop        (pop),
    .busy       (busy),
    .tx         (tx_o)
  );

endmodule

// File: tb/tb_dev_uart_tx.sv
// Self-checking bench for dev_uart_tx: bus accesses plus a frame-level model of the serial line.
// Honours UART_PARITY_EN to predict frame length, parity bit and STATUS[3].
module tb_dev_uart_tx;

`ifdef UART_PARITY_EN
  localparam int   NBITS = 11;
  localparam logic PAR   = 1'b1;
`else
  localparam int   NBITS = 10;
  localparam logic PAR   = 1'b0;
`endif
  localparam logic [31:0] ST_PAR = PAR ? 32'h8 : 32'h0;
  localparam logic [1:0]  R_TX = 2'd0, R_ST = 2'd1, R_DIV = 2'd2, R_RSV = 2'd3;

  logic        clk = 1'b0, rst = 1'b1, strobe = 1'b0, rw = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        ready, tx;
  logic [31:0] rdata_o;

  dev_uart_tx dut (
    .clk_i(clk), .rst_i(rst), .dev_strobe_i(strobe), .dev_addr_i(addr),
    .dev_rw_i(rw), .dev_byte_en_i(be), .dev_data_i(wdata),
    .dev_ready_o(ready), .dev_data_o(rdata_o), .tx_o(tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  logic [10:0] obs_first [32];
  logic [10:0] obs_last  [32];
  int          obs_gap   [32];
  int          obs_start [32];
  int          frame_div [32];
  bit          obs_timeout;
  logic [7:0]  sent [$];

  // Frame bit j: 0 = start, 1..8 = data LSB first, then parity (if built in), then stop; unused top bits are 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] v;
    v = '1;
    v[0] = 1'b0;
    v[8:1] = b;
    if (PAR) v[9] = ^b;
    return v;
  endfunction

  task automatic bus_access(input logic wr, input logic [1:0] idx, input logic [31:0] d,
                            input logic [3:0] lanes, output int lat, output logic [31:0] rd,
                            output int scyc);
    @(negedge clk);
    strobe = 1'b1; rw = wr; addr = {28'd0, idx, 2'b00}; wdata = d; be = lanes; scyc = cyc;
    @(negedge clk);
    strobe = 1'b0; rw = 1'b0; wdata = '0; be = '0; lat = 1;
    while (ready !== 1'b1 && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    if (ready !== 1'b1) lat = -1;
    rd = rdata_o;
  endtask

  task automatic sample_frames(input int n);
    int gap;
    obs_timeout = 1'b0;
    for (int f = 0; f < n; f++) begin
      obs_first[f] = '1;
      obs_last[f]  = '1;
      gap = 0;
      @(negedge clk);
      while (tx !== 1'b0 && gap < 3000) begin
        gap++;
        @(negedge clk);
      end
      if (tx !== 1'b0) begin
        obs_timeout = 1'b1;
        return;
      end
      obs_gap[f]   = gap;
      obs_start[f] = cyc;
      for (int j = 0; j < NBITS; j++) begin
        for (int k = 0; k < frame_div[f]; k++) begin
          if (j > 0 || k > 0) @(negedge clk);
          if (k == 0) obs_first[f][j] = tx;
          if (k == frame_div[f] - 1) obs_last[f][j] = tx;
        end
      end
    end
  endtask

  task automatic test_reset();
    int lat, s;
    logic [31:0] rd;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx got=%b want=1", tx); end
    checks++; if (ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b want=0", ready); end
    checks++; if (rdata_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%h want=0", rdata_o); end
    rst = 1'b0;
    bus_access(1'b0, R_ST, 32'h0, 4'h0, lat, rd, s);
    checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL status_latency got=%0d want=1", lat); end
    checks++; if (rd !== (32'h2 | ST_PAR)) begin failures++; $display("[TB] FAIL reset_status got=%h want=%h", rd, 32'h2 | ST_PAR); end
    bus_access(1'b0, R_DIV, 32'h0, 4'h0, lat, rd, s);
    checks++; if (rd !== 32'd868) begin failures++; $display("[TB] FAIL reset_divisor got=%0d want=868", rd); end
    bus_access(1'b0, R_RSV, 32'h0, 4'h0, lat, rd, s);
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reserved_read got=%h want=0", rd); end
    bus_access(1'b0, R_TX, 32'h0, 4'h0, lat, rd, s);
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL txdata_read got=%h want=0", rd); end
  endtask

  task automatic test_divisor_lanes();
    int lat, s;
    logic [31:0] rd, v;
    logic [3:0]  lanes;
    logic [15:0] model;
    model = 16'd868;
    for (int i = 0; i < 6; i++) begin
      v = $urandom;
      lanes = 4'($urandom_range(0, 15));
      bus_access(1'b1, R_DIV, v, lanes, lat, rd, s);
      if (lanes[0]) model[7:0]  = v[7:0];
      if (lanes[1]) model[15:8] = v[15:8];
      bus_access(1'b1, (i % 2 == 0) ? R_RSV : R_ST, $urandom, 4'hF, lat, rd, s);
      bus_access(1'b0, R_DIV, 32'h0, 4'h0, lat, rd, s);
      checks++;
      if (rd !== {16'd0, model}) begin
        failures++; $display("[TB] FAIL divisor_lanes[%0d] got=%h want=%h", i, rd, {16'd0, model});
      end
    end
  endtask

  task automatic test_single_frame();
    int lat, s, sd;
    logic [31:0] rd;
    logic [10:0] e;
    bus_access(1'b1, R_DIV, 32'd4, 4'h3, lat, rd, sd);
    frame_div[0] = 4;
    e = exp_frame(8'h55);
    fork
      sample_frames(1);
      bus_access(1'b1, R_TX, 32'h55, 4'h1, lat, rd, s);
    join
    checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL push_latency got=%0d want=1", lat); end
    checks++; if (obs_timeout !== 1'b0) begin failures++; $display("[TB] FAIL frame55_timeout got=1 want=0"); end
    checks++; if (obs_start[0] - s !== 2) begin failures++; $display("[TB] FAIL frame55_start got=%0d want=2", obs_start[0] - s); end
    checks++; if (obs_first[0] !== e) begin failures++; $display("[TB] FAIL frame55_first got=%b want=%b", obs_first[0], e); end
    checks++; if (obs_last[0] !== e) begin failures++; $display("[TB] FAIL frame55_last got=%b want=%b", obs_last[0], e); end
    bus_access(1'b0, R_ST, 32'h0, 4'h0, lat, rd, s);
    checks++; if (rd !== (32'h2 | ST_PAR)) begin failures++; $display("[TB] FAIL idle_status got=%h want=%h", rd, 32'h2 | ST_PAR); end
    checks++; if (tx !== 1'b1) begin failures++; $display("[TB] FAIL idle_tx got=%b want=1", tx); end
  endtask

  task automatic test_fifo_full();
    int lat, s, s1, s18, sd;
    logic [31:0] rd, want;
    logic [7:0]  b;
    bus_access(1'b1, R_DIV, 32'd20, 4'h3, lat, rd, sd);
    sent.delete();
    for (int i = 0; i < 18; i++) frame_div[i] = 20;
    fork
      sample_frames(18);
      begin
        for (int i = 0; i < 17; i++) begin
          b = 8'($urandom);
          sent.push_back(b);
          bus_access(1'b1, R_TX, {24'd0, b}, 4'h1, lat, rd, s);
          if (i == 0) s1 = s;
          checks++;
          if (lat !== 1) begin failures++; $display("[TB] FAIL fill_latency[%0d] got=%0d want=1", i, lat); end
        end
        bus_access(1'b0, R_ST, 32'h0, 4'h0, lat, rd, s);
        want = 32'h0000_1005 | ST_PAR;
        checks++; if (rd !== want) begin failures++; $display("[TB] FAIL full_status got=%h want=%h", rd, want); end
        b = 8'($urandom);
        sent.push_back(b);
        bus_access(1'b1, R_TX, {24'd0, b}, 4'h1, lat, rd, s18);
        checks++;
        if (s18 + lat !== s1 + 3 + NBITS * 20) begin
          failures++; $display("[TB] FAIL stalled_ack_cycle got=%0d want=%0d", s18 + lat, s1 + 3 + NBITS * 20);
        end
      end
    join
    checks++; if (obs_timeout !== 1'b0) begin failures++; $display("[TB] FAIL fifo_frames_timeout got=1 want=0"); end
    for (int f = 0; f < 18; f++) begin
      checks++;
      if (obs_first[f] !== exp_frame(sent[f]) || obs_last[f] !== exp_frame(sent[f])) begin
        failures++;
        $display("[TB] FAIL fifo_frame[%0d] got=%b/%b want=%b", f, obs_first[f], obs_last[f], exp_frame(sent[f]));
      end
      if (f > 0) begin
        checks++;
        if (obs_gap[f] !== 0) begin failures++; $display("[TB] FAIL fifo_gap[%0d] got=%0d want=0", f, obs_gap[f]); end
      end
    end
  endtask

  task automatic test_no_byte_enable();
    int lat, s, lows;
    logic [31:0] rd;
    bus_access(1'b1, R_TX, 32'h12, 4'h0, lat, rd, s);
    checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL nobe_latency got=%0d want=1", lat); end
    bus_access(1'b0, R_ST, 32'h0, 4'h0, lat, rd, s);
    checks++; if (rd !== (32'h2 | ST_PAR)) begin failures++; $display("[TB] FAIL nobe_status got=%h want=%h", rd, 32'h2 | ST_PAR); end
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin failures++; $display("[TB] FAIL nobe_tx_low_cycles got=%0d want=0", lows); end
  endtask

  task automatic test_div_zero();
    int lat, s, sx;
    logic [31:0] rd;
    logic [7:0]  b1, b2;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    bus_access(1'b1, R_DIV, 32'h0, 4'h3, lat, rd, sx);
    frame_div[0] = 1;
    frame_div[1] = 8;
    fork
      sample_frames(2);
      begin
        bus_access(1'b1, R_TX, {24'd0, b1}, 4'h1, lat, rd, s);
        bus_access(1'b1, R_DIV, 32'd8, 4'h3, lat, rd, sx);
        bus_access(1'b1, R_TX, {24'd0, b2}, 4'h1, lat, rd, sx);
      end
    join
    checks++; if (obs_timeout !== 1'b0) begin failures++; $display("[TB] FAIL div_frames_timeout got=1 want=0"); end
    checks++; if (obs_start[0] - s !== 2) begin failures++; $display("[TB] FAIL div0_start got=%0d want=2", obs_start[0] - s); end
    checks++;
    if (obs_first[0] !== exp_frame(b1) || obs_last[0] !== exp_frame(b1)) begin
      failures++; $display("[TB] FAIL div0_frame got=%b/%b want=%b", obs_first[0], obs_last[0], exp_frame(b1));
    end
    checks++;
    if (obs_first[1] !== exp_frame(b2) || obs_last[1] !== exp_frame(b2)) begin
      failures++; $display("[TB] FAIL div8_frame got=%b/%b want=%b", obs_first[1], obs_last[1], exp_frame(b2));
    end
    checks++; if (obs_gap[1] !== 0) begin failures++; $display("[TB] FAIL div8_gap got=%0d want=0", obs_gap[1]); end
  endtask

  task automatic test_reset_mid_frame();
    int lat, s, s1, d, lows, target;
    logic [31:0] rd;
    logic [7:0]  b;
    d = $urandom_range(6, 12);
    sent.delete();
    bus_access(1'b1, R_DIV, d, 4'h3, lat, rd, s);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      bus_access(1'b1, R_TX, {24'd0, b}, 4'h1, lat, rd, s);
      if (i == 0) s1 = s;
    end
    target = s1 + 2 + 4 * d + 1;
    while (cyc < target) @(negedge clk);
    checks++; if (tx !== sent[0][3]) begin failures++; $display("[TB] FAIL midframe_bit3 got=%b want=%b", tx, sent[0][3]); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("[TB] FAIL midreset_tx got=%b want=1", tx); end
    checks++; if (ready !== 1'b0) begin failures++; $display("[TB] FAIL midreset_ready got=%b want=0", ready); end
    rst = 1'b0;
    bus_access(1'b0, R_ST, 32'h0, 4'h0, lat, rd, s);
    checks++; if (rd !== (32'h2 | ST_PAR)) begin failures++; $display("[TB] FAIL midreset_status got=%h want=%h", rd, 32'h2 | ST_PAR); end
    bus_access(1'b0, R_DIV, 32'h0, 4'h0, lat, rd, s);
    checks++; if (rd !== 32'd868) begin failures++; $display("[TB] FAIL midreset_divisor got=%0d want=868", rd); end
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin failures++; $display("[TB] FAIL midreset_tx_low_cycles got=%0d want=0", lows); end
  endtask

  initial begin
    test_reset();
    test_divisor_lanes();
    test_single_frame();
    test_fifo_full();
    test_no_byte_enable();
    test_div_zero();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("[TB] FAIL watchdog got=timeout want=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
